// File: rtl/xor_bank_writer_uram.sv
// Single-bank writer for an XOR-coded URAM array: reads the other banks at the
// write address and stores wr_data XOR'd with them, so the XOR of all lanes decodes to wr_data.
module xor_bank_writer_uram #(
   parameter int NUM_XOR    = 16,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 12,
   parameter int BANK_ID    = 0,
   parameter int RD_LATENCY = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_valid,
   output logic                          wr_ready,
   input  logic [ADDR_WIDTH-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   output logic                          rd_en,
   output logic [ADDR_WIDTH-1:0]         rd_addr,
   input  logic [NUM_XOR*DATA_WIDTH-1:0] rd_data,
   output logic                          bank_we,
   output logic [ADDR_WIDTH-1:0]         bank_addr,
   output logic [DATA_WIDTH-1:0]         bank_wdata
);

   localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [ADDR_WIDTH-1:0]   baddr_q, baddr_d;
   logic [DATA_WIDTH-1:0]   bdata_q, bdata_d;
   logic [DATA_WIDTH-1:0]   xor_other;
   logic                    own_lane_unused;

   // Our own lane holds the value being replaced, so it never enters the code word.
   always_comb begin
      xor_other = '0;
      for (int unsigned i = 0; i < NUM_XOR; i++) begin
         if (i != unsigned'(BANK_ID))
            xor_other = xor_other ^ rd_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
      own_lane_unused = ^rd_data[DATA_WIDTH*BANK_ID +: DATA_WIDTH];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      baddr_d = baddr_q;
      bdata_d = bdata_q;
      rd_en   = 1'b0;
      bank_we = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wr_valid && ready_q) begin
               addr_d  = wr_addr;
               data_d  = wr_data;
               state_d = READ;
            end
         end
         READ: begin
            rd_en   = 1'b1;
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == CNT_LAST) begin
               bdata_d = data_q ^ xor_other;
               baddr_d = addr_q;
               cnt_d   = '0;
               state_d = WRITE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WRITE: begin
            bank_we = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Registered so that ready stays low while rst is held.
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         baddr_q <= '0;
         bdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         baddr_q <= baddr_d;
         bdata_q <= bdata_d;
      end
   end

   always_comb begin
      wr_ready   = ready_q;
      rd_addr    = addr_q;
      bank_addr  = baddr_q;
      bank_wdata = bdata_q;
   end

endmodule
